mem_access_unit: RTL and testbench



---
 rtl/mem_access_pkg.sv | 20 ++
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_lane_format.sv | 53 +++++
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage access unit: FSM states,
// byte-enable patterns and timeout defaults.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
    localparam int unsigned TIMEOUT_W_DEF      = 8;

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-outstanding word bus between the MEM-stage unit and memory.
interface mem_access_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_lane_format.sv
// Little-endian lane handling: byte enables, store-data replication and
// load-data extraction with sign/zero extension. Purely combinational.
module mem_lane_format
    import mem_access_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        size_byte,
    input  logic        size_half,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the loaded word.
    always_comb begin
        byte_sel = load_word[7:0];
        case (lane)
            2'd0:    byte_sel = load_word[7:0];
            2'd1:    byte_sel = load_word[15:8];
            2'd2:    byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
        half_sel = lane[1] ? load_word[31:16] : load_word[15:0];
    end

    // Size-dependent enables, replication, extension and alignment check.
    always_comb begin
        be         = BE_WORD;
        store_word = store_data;
        load_data  = load_word;
        misaligned = 1'b0;
        if (size_byte) begin
            be         = BE_BYTE0 << lane;
            store_word = {4{store_data[7:0]}};
            load_data  = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
        end else if (size_half) begin
            be         = lane[1] ? BE_HALF_HI : BE_HALF_LO;
            store_word = {2{store_data[15:0]}};
            load_data  = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
            misaligned = lane[0];
        end else begin
            misaligned = (lane != 2'd0);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: one outstanding word-bus transaction,
// load formatting, LL/SC reservation and pipeline stall generation.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_W      = TIMEOUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic                 mem_read,
    input  logic                 mem_we,
    input  logic                 mem_byte,
    input  logic                 mem_halfword,
    input  logic                 mem_signextend,
    input  logic                 mem_ll,
    input  logic                 mem_sc,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic                 stall_mem,
    output logic                 resp_valid,
    output logic [31:0]          rdata,
    output logic                 addr_err,
    output logic                 bus_err,
    mem_access_unit_if.master    bus,
    input  logic                 snoop_inval,
    input  logic [31:0]          snoop_addr
);

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                state, state_d;
    logic [TIMEOUT_W-1:0]  tmo_cnt;

    logic [31:0] bus_addr_q, bus_wdata_q, rdata_q;
    logic [3:0]  bus_be_q;
    logic        we_q, byte_q, half_q, sext_q, ll_q, sc_q;
    logic [1:0]  lane_q;

    logic        link_valid, link_valid_d;
    logic [29:0] link_addr, link_addr_d;

    logic        access, sc_hit, accept, sc_reject, bus_done, timeout;

    logic [1:0]  fmt_lane;
    logic        fmt_byte, fmt_half, fmt_sext;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata, fmt_load;
    logic        fmt_misaligned;

    logic        unused_snoop_lo;
    assign unused_snoop_lo = ^snoop_addr[1:0];

    assign access = rst_n & req_valid & (mem_read | mem_we);
    assign sc_hit = link_valid && (link_addr == addr[31:2]);

    // One formatter serves both paths: request fields while idle, the
    // latched request while the transaction is in flight.
    assign fmt_lane = (state == IDLE) ? addr[1:0]      : lane_q;
    assign fmt_byte = (state == IDLE) ? mem_byte       : byte_q;
    assign fmt_half = (state == IDLE) ? mem_halfword   : half_q;
    assign fmt_sext = (state == IDLE) ? mem_signextend : sext_q;

    mem_lane_format u_fmt (
        .lane       (fmt_lane),
        .size_byte  (fmt_byte),
        .size_half  (fmt_half),
        .sign_ext   (fmt_sext),
        .store_data (wdata),
        .load_word  (bus.bus_rdata),
        .be         (fmt_be),
        .store_word (fmt_wdata),
        .load_data  (fmt_load),
        .misaligned (fmt_misaligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state and per-cycle control/handshake outputs.
    always_comb begin
        state_d    = state;
        stall_mem  = 1'b0;
        resp_valid = 1'b0;
        addr_err   = 1'b0;
        bus_err    = 1'b0;
        accept     = 1'b0;
        sc_reject  = 1'b0;
        bus_done   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (fmt_misaligned) begin
                        addr_err = 1'b1;
                    end else if (mem_sc && !sc_hit) begin
                        resp_valid = 1'b1;
                        sc_reject  = 1'b1;
                    end else begin
                        stall_mem = 1'b1;
                        accept    = 1'b1;
                        state_d   = BUS;
                    end
                end
            end
            BUS: begin
                stall_mem = 1'b1;
                if (bus.bus_ack) begin
                    bus_done = 1'b1;
                    state_d  = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    bus_err = 1'b1;
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reservation update; the snoop is applied last so it overrides an
    // LL completing to the same word in the same cycle.
    always_comb begin
        link_valid_d = link_valid;
        link_addr_d  = link_addr;
        if (sc_reject) link_valid_d = 1'b0;
        if (bus_done) begin
            if (ll_q) begin
                link_valid_d = 1'b1;
                link_addr_d  = bus_addr_q[31:2];
            end
            if (we_q && (bus_addr_q[31:2] == link_addr)) link_valid_d = 1'b0;
            if (sc_q) link_valid_d = 1'b0;
        end
        if (snoop_inval && (snoop_addr[31:2] == link_addr_d)) link_valid_d = 1'b0;
    end

    // Latched request, bus fields, timeout counter, response data and link.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= BE_NONE;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            half_q      <= 1'b0;
            sext_q      <= 1'b0;
            ll_q        <= 1'b0;
            sc_q        <= 1'b0;
            lane_q      <= '0;
            tmo_cnt     <= '0;
            rdata_q     <= '0;
            link_valid  <= 1'b0;
            link_addr   <= '0;
        end else begin
            if (accept) begin
                bus_addr_q  <= {addr[31:2], 2'b00};
                bus_wdata_q <= fmt_wdata;
                bus_be_q    <= fmt_be;
                we_q        <= mem_we;
                byte_q      <= mem_byte;
                half_q      <= mem_halfword;
                sext_q      <= mem_signextend;
                ll_q        <= mem_ll;
                sc_q        <= mem_sc;
                lane_q      <= addr[1:0];
                tmo_cnt     <= '0;
            end else if (state == BUS && !bus.bus_ack) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (bus_done)     rdata_q <= sc_q ? 32'd1 : (we_q ? '0 : fmt_load);
            else if (timeout) rdata_q <= '0;
            link_valid <= link_valid_d;
            link_addr  <= link_addr_d;
        end
    end

    assign rdata         = sc_reject ? '0 : rdata_q;
    assign bus.bus_req   = (state == BUS);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, stores, misalignment,
// LL/SC reservation, snoop invalidation, timeout and mid-transaction reset.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, mem_read, mem_we, mem_byte, mem_halfword;
    logic        mem_signextend, mem_ll, mem_sc;
    logic [31:0] addr, wdata;
    logic        stall_mem, resp_valid, addr_err, bus_err;
    logic [31:0] rdata;
    logic        snoop_inval;
    logic [31:0] snoop_addr;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if bus_if();

    mem_access_unit #(
        .TIMEOUT_CYCLES (255),
        .TIMEOUT_W      (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .mem_read       (mem_read),
        .mem_we         (mem_we),
        .mem_byte       (mem_byte),
        .mem_halfword   (mem_halfword),
        .mem_signextend (mem_signextend),
        .mem_ll         (mem_ll),
        .mem_sc         (mem_sc),
        .addr           (addr),
        .wdata          (wdata),
        .stall_mem      (stall_mem),
        .resp_valid     (resp_valid),
        .rdata          (rdata),
        .addr_err       (addr_err),
        .bus_err        (bus_err),
        .bus            (bus_if.master),
        .snoop_inval    (snoop_inval),
        .snoop_addr     (snoop_addr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req;
        req_valid = 0; mem_read = 0; mem_we = 0; mem_byte = 0; mem_halfword = 0;
        mem_signextend = 0; mem_ll = 0; mem_sc = 0; addr = '0; wdata = '0;
    endtask

    task automatic set_req(input logic rd, input logic we, input logic by, input logic hw,
                           input logic sx, input logic ll, input logic sc,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1; mem_read = rd; mem_we = we; mem_byte = by; mem_halfword = hw;
        mem_signextend = sx; mem_ll = ll; mem_sc = sc; addr = a; wdata = wd;
    endtask

    // Word LL/SC/SW/LW stimulus with ack in the first bus cycle; returns
    // what was observed, the calling test judges it.
    task automatic bus_word(input logic ll, input logic sc, input logic st,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdw,
                            input logic snp, input logic [31:0] snp_a,
                            output logic went_bus, output logic done_resp,
                            output logic [31:0] done_rdata);
        set_req(!st, st, 0, 0, 0, ll, sc, a, wd);
        #4;
        went_bus   = stall_mem;
        done_resp  = resp_valid;
        done_rdata = rdata;
        tick;
        if (went_bus) begin
            bus_if.bus_ack = 1; bus_if.bus_rdata = rdw;
            snoop_inval = snp; snoop_addr = snp_a;
            #4;
            went_bus = bus_if.bus_req;
            tick;
            bus_if.bus_ack = 0; snoop_inval = 0; clear_req;
            #4;
            done_resp  = resp_valid;
            done_rdata = rdata;
            tick;
        end else begin
            clear_req;
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick; tick;
        #4;
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_mem); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", resp_valid); end
        checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus_if.bus_req); end
        checks++; if (bus_if.bus_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus_if.bus_we); end
        checks++; if (bus_if.bus_be !== 4'b0000) begin errors++; $display("FAIL reset_be: got %b want 0000", bus_if.bus_be); end
        checks++; if (bus_if.bus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus_if.bus_addr); end
        checks++; if (bus_if.bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus_if.bus_wdata); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if ((addr_err | bus_err) !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b want 00", addr_err, bus_err); end
        tick;
        rst_n = 1;
        tick;
    endtask

    task automatic test_load(input string tag, input logic [31:0] a, input logic by, input logic hw,
                             input logic sx, input logic [31:0] rdw,
                             input logic [3:0] exp_be, input logic [31:0] exp_rd);
        int stalls = 0;
        set_req(1, 0, by, hw, sx, 0, 0, a, '0);
        #4;
        checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL %s_accept_stall: got %b want 1", tag, stall_mem); end
        checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL %s_accept_req: got %b want 0", tag, bus_if.bus_req); end
        stalls += int'(stall_mem);
        tick;
        bus_if.bus_ack = 1; bus_if.bus_rdata = rdw;
        #4;
        checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL %s_bus_req: got %b want 1", tag, bus_if.bus_req); end
        checks++; if (bus_if.bus_be !== exp_be) begin errors++; $display("FAIL %s_be: got %b want %b", tag, bus_if.bus_be, exp_be); end
        checks++; if (bus_if.bus_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr: got %h want %h", tag, bus_if.bus_addr, {a[31:2], 2'b00}); end
        checks++; if (bus_if.bus_we !== 1'b0) begin errors++; $display("FAIL %s_we: got %b want 0", tag, bus_if.bus_we); end
        stalls += int'(stall_mem);
        tick;
        bus_if.bus_ack = 0; clear_req;
        #4;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL %s_resp: got %b want 1", tag, resp_valid); end
        checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL %s_rdata: got %h want %h", tag, rdata, exp_rd); end
        checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL %s_req_drop: got %b want 0", tag, bus_if.bus_req); end
        stalls += int'(stall_mem);
        tick;
        #4;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s_resp_pulse: got %b want 0", tag, resp_valid); end
        checks++; if (stalls != 2) begin errors++; $display("FAIL %s_stall_cycles: got %0d want 2", tag, stalls); end
        tick;
    endtask

    task automatic test_store;
        set_req(0, 1, 0, 1, 0, 0, 0, 32'h0000_2002, 32'h0000_BEEF);
        #4;
        checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL sh_accept_stall: got %b want 1", stall_mem); end
        tick;
        #4;
        checks++; if (bus_if.bus_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", bus_if.bus_be); end
        checks++; if (bus_if.bus_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata: got %h want beefbeef", bus_if.bus_wdata); end
        checks++; if (bus_if.bus_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b want 1", bus_if.bus_we); end
        tick;
        // second bus cycle without ack: fields must hold
        bus_if.bus_ack = 1;
        #4;
        checks++; if (bus_if.bus_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr_hold: got %h want 00002000", bus_if.bus_addr); end
        checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL sh_req_hold: got %b want 1", bus_if.bus_req); end
        tick;
        bus_if.bus_ack = 0; clear_req;
        #4;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sh_resp: got %b want 1", resp_valid); end
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL sh_done_stall: got %b want 0", stall_mem); end
        tick;
        #4;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sh_resp_pulse: got %b want 0", resp_valid); end
        tick;
        // byte store lane replication
        set_req(0, 1, 1, 0, 0, 0, 0, 32'h0000_2001, 32'h1234_56A5);
        tick;
        bus_if.bus_ack = 1;
        #4;
        checks++; if (bus_if.bus_be !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b want 0010", bus_if.bus_be); end
        checks++; if (bus_if.bus_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", bus_if.bus_wdata); end
        tick;
        bus_if.bus_ack = 0; clear_req;
        tick;
    endtask

    task automatic test_misaligned;
        set_req(1, 0, 0, 0, 0, 0, 0, 32'h0000_3001, '0);
        #4;
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL lw_mis_err: got %b want 1", addr_err); end
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL lw_mis_stall: got %b want 0", stall_mem); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lw_mis_resp: got %b want 0", resp_valid); end
        tick;
        clear_req;
        #4;
        checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL lw_mis_req: got %b want 0", bus_if.bus_req); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL lw_mis_pulse: got %b want 0", addr_err); end
        tick;
        set_req(0, 1, 0, 1, 0, 0, 0, 32'h0000_3003, '0);
        #4;
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL sh_mis_err: got %b want 1", addr_err); end
        tick;
        clear_req;
        #4;
        checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL sh_mis_req: got %b want 0", bus_if.bus_req); end
        tick;
    endtask

    task automatic test_ll_sc;
        logic wb, rv;
        logic [31:0] rd;
        bus_word(1, 0, 0, 32'h0000_4000, '0, 32'h1234_5678, 0, '0, wb, rv, rd);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ll_rdata: got %h want 12345678", rd); end
        bus_word(0, 1, 1, 32'h0000_4000, 32'hAAAA_5555, '0, 0, '0, wb, rv, rd);
        checks++; if (wb !== 1'b1) begin errors++; $display("FAIL sc_ok_bus: got %b want 1", wb); end
        checks++; if (rv !== 1'b1 || rd !== 32'h1) begin errors++; $display("FAIL sc_ok_rdata: got resp=%b rdata=%h want 1/00000001", rv, rd); end
        bus_word(0, 1, 1, 32'h0000_4000, 32'hAAAA_5555, '0, 0, '0, wb, rv, rd);
        checks++; if (wb !== 1'b0) begin errors++; $display("FAIL sc_again_bus: got %b want 0", wb); end
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sc_again_rdata: got resp=%b rdata=%h want 1/00000000", rv, rd); end
        #4;
        checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL sc_again_req: got %b want 0", bus_if.bus_req); end
        tick;
        // plain store to the linked word kills the reservation
        bus_word(1, 0, 0, 32'h0000_A000, '0, 32'h0, 0, '0, wb, rv, rd);
        bus_word(0, 0, 1, 32'h0000_A000, 32'h5, '0, 0, '0, wb, rv, rd);
        bus_word(0, 1, 1, 32'h0000_A000, 32'h6, '0, 0, '0, wb, rv, rd);
        checks++; if (wb !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sc_after_sw: got bus=%b rdata=%h want 0/00000000", wb, rd); end
    endtask

    task automatic test_snoop;
        logic wb, rv;
        logic [31:0] rd;
        bus_word(1, 0, 0, 32'h0000_5000, '0, 32'h0, 0, '0, wb, rv, rd);
        snoop_inval = 1; snoop_addr = 32'h0000_5002;
        tick;
        snoop_inval = 0;
        bus_word(0, 1, 1, 32'h0000_5000, 32'h77, '0, 0, '0, wb, rv, rd);
        checks++; if (wb !== 1'b0) begin errors++; $display("FAIL snoop_sc_bus: got %b want 0", wb); end
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL snoop_sc_rdata: got resp=%b rdata=%h want 1/00000000", rv, rd); end
        // snoop in the same cycle as LL completion wins
        bus_word(1, 0, 0, 32'h0000_6000, '0, 32'h0, 1, 32'h0000_6001, wb, rv, rd);
        bus_word(0, 1, 1, 32'h0000_6000, 32'h1, '0, 0, '0, wb, rv, rd);
        checks++; if (wb !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL snoop_ll_race: got bus=%b rdata=%h want 0/00000000", wb, rd); end
        // snoop to a different word leaves the link intact
        bus_word(1, 0, 0, 32'h0000_7000, '0, 32'h0, 0, '0, wb, rv, rd);
        snoop_inval = 1; snoop_addr = 32'h0000_7004;
        tick;
        snoop_inval = 0;
        bus_word(0, 1, 1, 32'h0000_7000, 32'h1, '0, 0, '0, wb, rv, rd);
        checks++; if (wb !== 1'b1 || rd !== 32'h1) begin errors++; $display("FAIL snoop_other_word: got bus=%b rdata=%h want 1/00000001", wb, rd); end
    endtask

    task automatic test_timeout;
        int err_at = 0;
        bus_if.bus_ack = 0;
        set_req(1, 0, 0, 0, 0, 0, 0, 32'h0000_8000, '0);
        tick;
        for (int i = 1; i <= 300; i++) begin
            #4;
            if (bus_err === 1'b1) begin
                err_at = i;
                break;
            end
            tick;
        end
        checks++; if (err_at != 255) begin errors++; $display("FAIL tmo_cycle: got %0d want 255", err_at); end
        checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL tmo_req_at_err: got %b want 1", bus_if.bus_req); end
        tick;
        clear_req;
        #4;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL tmo_resp: got %b want 1", resp_valid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h want 0", rdata); end
        checks++; if (bus_err !== 1'b0 || bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL tmo_after: got err=%b req=%b want 0/0", bus_err, bus_if.bus_req); end
        tick;
    endtask

    task automatic test_reset_mid_bus;
        int resp_seen = 0;
        set_req(1, 0, 0, 0, 0, 0, 0, 32'h0000_9000, '0);
        tick;
        #4;
        checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL rstbus_req: got %b want 1", bus_if.bus_req); end
        tick;
        rst_n = 0;
        tick;
        #4;
        checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rstbus_req_drop: got %b want 0", bus_if.bus_req); end
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL rstbus_stall: got %b want 0", stall_mem); end
        resp_seen += int'(resp_valid);
        tick;
        rst_n = 1; clear_req;
        for (int i = 0; i < 5; i++) begin
            #4;
            resp_seen += int'(resp_valid);
            tick;
        end
        checks++; if (resp_seen != 0) begin errors++; $display("FAIL rstbus_no_resp: got %0d want 0", resp_seen); end
    endtask

    initial begin
        rst_n = 0;
        clear_req;
        bus_if.bus_ack = 0;
        bus_if.bus_rdata = '0;
        snoop_inval = 0;
        snoop_addr = '0;
        test_reset;
        test_load("lb",  32'h0000_1003, 1, 0, 1, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
        test_load("lb1", 32'h0000_1001, 1, 0, 1, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
        test_load("lhu", 32'h0000_1002, 0, 1, 0, 32'h80FF_1234, 4'b1100, 32'h0000_80FF);
        test_load("lh",  32'h0000_1000, 0, 1, 1, 32'h0000_8001, 4'b0011, 32'hFFFF_8001);
        test_load("lw",  32'h0000_1004, 0, 0, 0, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        test_store;
        test_misaligned;
        test_ll_sc;
        test_snoop;
        test_timeout;
        test_reset_mid_bus;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
